// File: rtl/order_tx_serializer_if.sv
// Egress stream bundle for order_tx_serializer: core-side pair capture plus the
// valid/ready beat stream and status counters toward the MAC.
interface order_tx_serializer_if #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 9,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                          i_valid;
    logic [NUM_REGS*REG_WIDTH-1:0] i_buy_msg;
    logic [NUM_REGS*REG_WIDTH-1:0] i_sell_msg;
    logic                          i_tx_ready;
    logic [REG_WIDTH-1:0]          o_tx_data;
    logic                          o_tx_valid;
    logic                          o_tx_last;
    logic                          o_tx_side;
    logic                          o_fifo_full;
    logic [CNT_WIDTH-1:0]          o_sent_count;
    logic [CNT_WIDTH-1:0]          o_drop_count;

    modport slave (
        input  i_valid, i_buy_msg, i_sell_msg, i_tx_ready,
        output o_tx_data, o_tx_valid, o_tx_last, o_tx_side, o_fifo_full,
               o_sent_count, o_drop_count
    );

    modport master (
        output i_valid, i_buy_msg, i_sell_msg, i_tx_ready,
        input  o_tx_data, o_tx_valid, o_tx_last, o_tx_side, o_fifo_full,
               o_sent_count, o_drop_count
    );
endinterface

// File: rtl/order_tx_serializer.sv
// Buffers buy/sell order pairs in a small FIFO and serializes each pair as the
// full buy message then the full sell message on a valid/ready beat stream.
module order_tx_serializer #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned NUM_REGS   = 9,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    order_tx_serializer_if.slave  bus
);
    localparam int unsigned MSG_W = NUM_REGS * REG_WIDTH;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {StIdle, StSendBuy, StSendSell} state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     count_q, count_d;
    logic [CNT_WIDTH-1:0] sent_q, drop_q;
    logic [2*MSG_W-1:0]   mem_q [FIFO_DEPTH];

    logic                 full, push, drop, pop;
    logic                 tx_valid, tx_last, tx_side;
    logic [MSG_W-1:0]     head_msg;
    logic [REG_WIDTH-1:0] tx_data;

    // Fullness uses the registered occupancy, so a same-cycle pop never makes room.
    assign full = (count_q == OCC_FULL);
    assign push = bus.i_valid && !full;
    assign drop = bus.i_valid && full;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_side  = 1'b0;
        pop      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d = StSendBuy;
                    idx_d   = '0;
                end
            end
            StSendBuy: begin
                tx_valid = 1'b1;
                tx_last  = (idx_q == IDX_LAST);
                if (bus.i_tx_ready) begin
                    if (tx_last) begin
                        state_d = StSendSell;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSendSell: begin
                tx_valid = 1'b1;
                tx_side  = 1'b1;
                tx_last  = (idx_q == IDX_LAST);
                if (bus.i_tx_ready) begin
                    if (tx_last) begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        // Another pair already waiting: start it without a bubble.
                        state_d = (count_q > OCC_W'(1)) ? StSendBuy : StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Entries hold {buy, sell}; buy occupies the upper half.
    always_comb begin
        head_msg = (state_q == StSendSell) ? mem_q[rd_ptr_q][MSG_W-1:0]
                                           : mem_q[rd_ptr_q][2*MSG_W-1:MSG_W];
        tx_data  = '0;
        if (tx_valid) begin
            tx_data = head_msg[int'(idx_q)*REG_WIDTH +: REG_WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.i_buy_msg, bus.i_sell_msg};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sent_q   <= '0;
            drop_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop && (sent_q != '1)) begin
                sent_q <= sent_q + 1'b1;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign bus.o_tx_data    = tx_data;
    assign bus.o_tx_valid   = tx_valid;
    assign bus.o_tx_last    = tx_last;
    assign bus.o_tx_side    = tx_side;
    assign bus.o_fifo_full  = full;
    assign bus.o_sent_count = sent_q;
    assign bus.o_drop_count = drop_q;
endmodule

// File: tb/tb_order_tx_serializer.sv
// Directed bench for order_tx_serializer: latency, back-pressure, overflow,
// back-to-back pairs, drop with simultaneous pop, and reset mid-message.
module tb_order_tx_serializer;
    localparam int unsigned REG_WIDTH  = 32;
    localparam int unsigned NUM_REGS   = 9;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CNT_WIDTH  = 16;
    localparam int unsigned MSG_W      = NUM_REGS * REG_WIDTH;
    localparam int          PAIR_BEATS = 2 * NUM_REGS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_used;

    always #5 clk = ~clk;

    order_tx_serializer_if #(
        .REG_WIDTH(REG_WIDTH),
        .NUM_REGS (NUM_REGS),
        .CNT_WIDTH(CNT_WIDTH)
    ) bus ();

    order_tx_serializer #(
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .bus      (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pair p, word k: buy = 0x1000*p + 0x100 + k, sell = 0x1000*p + 0x200 + k.
    function automatic logic [31:0] word(input int p, input bit side, input int k);
        return 32'(p * 'h1000 + (side ? 'h200 : 'h100) + k);
    endfunction

    function automatic logic [MSG_W-1:0] msg(input int p, input bit side);
        logic [MSG_W-1:0] m;
        for (int k = 0; k < NUM_REGS; k++) m[k*REG_WIDTH +: REG_WIDTH] = word(p, side, k);
        return m;
    endfunction

    task automatic push_pair(input int p);
        bus.i_valid    = 1'b1;
        bus.i_buy_msg  = msg(p, 1'b0);
        bus.i_sell_msg = msg(p, 1'b1);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_valid    = 1'b0;
        bus.i_tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rst_sent", 32'(bus.o_sent_count), 32'd0);
        check("rst_drop", 32'(bus.o_drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.o_tx_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_valid", 32'(bus.o_tx_valid), 32'd1);
    endtask

    // Called at a negedge; drives ready each cycle and checks every transferred beat
    // plus stability of held beats. Stops after nbeats transfers or the budget.
    task automatic run_stream(input int first_p, input int nbeats, input bit alt,
                              input int budget, output int cycles);
        int          beat = 0;
        int          cyc = 0;
        int          gaps = 0;
        int          idx;
        bit          rdy;
        bit          holding = 1'b0;
        logic [31:0] h_data;
        logic        h_last, h_side;
        while (beat < nbeats && cyc < budget) begin
            rdy = alt ? (cyc % 2 == 0) : 1'b1;
            if (holding) begin
                check("hold_valid", 32'(bus.o_tx_valid), 32'd1);
                check("hold_data", bus.o_tx_data, h_data);
                check("hold_last", 32'(bus.o_tx_last), 32'(h_last));
                check("hold_side", 32'(bus.o_tx_side), 32'(h_side));
            end
            if (bus.o_tx_valid) begin
                idx = beat % PAIR_BEATS;
                if (rdy) begin
                    check("beat_data", bus.o_tx_data,
                          word(first_p + beat / PAIR_BEATS, idx >= NUM_REGS, idx % NUM_REGS));
                    check("beat_side", 32'(bus.o_tx_side), 32'(idx >= NUM_REGS));
                    check("beat_last", 32'(bus.o_tx_last), 32'(idx % NUM_REGS == NUM_REGS - 1));
                    beat++;
                end
                holding = !rdy;
                h_data  = bus.o_tx_data;
                h_last  = bus.o_tx_last;
                h_side  = bus.o_tx_side;
            end else begin
                gaps++;
                holding = 1'b0;
            end
            bus.i_tx_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        bus.i_tx_ready = 1'b0;
        check("stream_beats", 32'(beat), 32'(nbeats));
        check("stream_gaps", 32'(gaps), 32'd0);
        cycles = cyc;
    endtask

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_buy_msg  = '0;
        bus.i_sell_msg = '0;
        bus.i_tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(bus.o_tx_valid), 32'd0);
        check("reset_data", bus.o_tx_data, 32'd0);
        check("reset_last", 32'(bus.o_tx_last), 32'd0);
        check("reset_side", 32'(bus.o_tx_side), 32'd0);
        check("reset_full", 32'(bus.o_fifo_full), 32'd0);
        check("reset_cnts", 32'({bus.o_sent_count, bus.o_drop_count}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single pair, ready high; valid appears two cycles after the strobe.
        bus.i_tx_ready = 1'b1;
        push_pair(0);
        check("lat_cycle1", 32'(bus.o_tx_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(bus.o_tx_valid), 32'd1);
        run_stream(0, PAIR_BEATS, 1'b0, 40, cyc_used);
        check("single_cycles", 32'(cyc_used), 32'(PAIR_BEATS));
        check("single_sent", 32'(bus.o_sent_count), 32'd1);
        check("single_idle", 32'(bus.o_tx_valid), 32'd0);

        // 2: ready alternating 1,0; beats land on the high phases -> 35 cycles.
        do_reset();
        push_pair(5);
        wait_valid(10);
        run_stream(5, PAIR_BEATS, 1'b1, 80, cyc_used);
        check("bp_cycles", 32'(cyc_used), 32'(2 * PAIR_BEATS - 1));
        check("bp_idle", 32'(bus.o_tx_valid), 32'd0);
        check("bp_sent", 32'(bus.o_sent_count), 32'd1);

        // 3: overflow with ready held low, six strobes into a 4-deep FIFO.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_pair(10 + i);
            check("ovf_full", 32'(bus.o_fifo_full), 32'(i >= 3));
        end
        check("ovf_drop", 32'(bus.o_drop_count), 32'd2);
        run_stream(10, 4 * PAIR_BEATS, 1'b0, 200, cyc_used);
        check("ovf_sent", 32'(bus.o_sent_count), 32'd4);
        check("ovf_idle", 32'(bus.o_tx_valid), 32'd0);
        check("ovf_notfull", 32'(bus.o_fifo_full), 32'd0);

        // 4: two queued pairs stream back to back.
        do_reset();
        push_pair(20);
        push_pair(21);
        run_stream(20, 2 * PAIR_BEATS, 1'b0, 100, cyc_used);
        check("b2b_cycles", 32'(cyc_used), 32'(2 * PAIR_BEATS));
        check("b2b_sent", 32'(bus.o_sent_count), 32'd2);

        // 5: strobe while full, coinciding with the final sell beat of the head.
        do_reset();
        for (int i = 0; i < 4; i++) push_pair(30 + i);
        check("pp_full", 32'(bus.o_fifo_full), 32'd1);
        run_stream(30, PAIR_BEATS - 1, 1'b0, 40, cyc_used);
        check("pp_lastdata", bus.o_tx_data, word(30, 1'b1, NUM_REGS - 1));
        check("pp_lastflag", 32'(bus.o_tx_last), 32'd1);
        bus.i_tx_ready = 1'b1;
        push_pair(39);
        check("pp_drop", 32'(bus.o_drop_count), 32'd1);
        check("pp_sent", 32'(bus.o_sent_count), 32'd1);
        check("pp_occ3", 32'(bus.o_fifo_full), 32'd0);
        run_stream(31, 3 * PAIR_BEATS, 1'b0, 100, cyc_used);
        check("pp_sent_end", 32'(bus.o_sent_count), 32'd4);
        check("pp_idle", 32'(bus.o_tx_valid), 32'd0);

        // 6: reset after buy beat 5; buffered pair 42 must be discarded.
        do_reset();
        push_pair(40);
        wait_valid(10);
        run_stream(40, PAIR_BEATS, 1'b0, 40, cyc_used);
        push_pair(41);
        push_pair(42);
        wait_valid(10);
        run_stream(41, 5, 1'b0, 20, cyc_used);
        check("rm_pre_sent", 32'(bus.o_sent_count), 32'd1);
        bus.i_tx_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rm_valid", 32'(bus.o_tx_valid), 32'd0);
        check("rm_data", bus.o_tx_data, 32'd0);
        check("rm_sent", 32'(bus.o_sent_count), 32'd0);
        check("rm_drop", 32'(bus.o_drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rm_empty", 32'(bus.o_tx_valid), 32'd0);
        push_pair(43);
        wait_valid(10);
        run_stream(43, PAIR_BEATS, 1'b0, 40, cyc_used);
        check("rm_new_sent", 32'(bus.o_sent_count), 32'd1);
        check("rm_new_idle", 32'(bus.o_tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
